// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: resolves hits combinationally and
// sequences victim writeback plus word-by-word refill on a miss. Optional statistics: CACHE_STATS_EN.
module cache_ctrl #(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_din,
  output logic        cache_load,
  output logic        cache_edit,
  output logic        cache_invalid,
  input  logic        cache_hit,
  input  logic        cache_valid,
  input  logic        cache_dirty,
  input  logic [31:0] cache_dout,
  input  logic [21:0] cache_tag,
  output logic [31:0] mem_addr,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [1:0] {IDLE, BACK, FILL, FINISH} state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic       req_s, last_word_s;

  assign req_s       = cpu_rd | cpu_wr;
  assign last_word_s = (cnt_r == 3'(LINE_WORDS - 1));

  // state and word counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // next state and all outputs; everything is forced low while reset is held
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cpu_dout      = 32'd0;
    cpu_stall     = 1'b0;
    cache_addr    = 32'd0;
    cache_din     = 32'd0;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_invalid = 1'b0;
    mem_addr      = 32'd0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_dout      = 32'd0;
    if (!rst) begin
      case (state_r)
        IDLE: begin
          cache_addr = cpu_addr;
          if (req_s) begin
            if (cache_hit) begin
              if (cpu_wr) begin
                cache_edit = 1'b1;
                cache_din  = cpu_din;
              end else begin
                cpu_dout = cache_dout;
              end
            end else begin
              cpu_stall   = 1'b1;
              cnt_nxt_s   = 3'd0;
              state_nxt_s = (cache_valid & cache_dirty) ? BACK : FILL;
            end
          end else begin
            cpu_stall = 1'b0;
          end
        end
        BACK: begin
          // cache_line indexes by line only, so cache_dout here is the victim word
          cpu_stall  = 1'b1;
          cache_addr = {cpu_addr[31:5], cnt_r, 2'b00};
          mem_addr   = {cache_tag, cpu_addr[9:5], cnt_r, 2'b00};
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_dout   = cache_dout;
          if (mem_ack) begin
            cnt_nxt_s = cnt_r + 3'd1;
            if (last_word_s) begin
              cnt_nxt_s   = 3'd0;
              state_nxt_s = FILL;
            end else begin
              state_nxt_s = BACK;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        FILL: begin
          cpu_stall  = 1'b1;
          cache_addr = {cpu_addr[31:5], cnt_r, 2'b00};
          mem_addr   = {cpu_addr[31:5], cnt_r, 2'b00};
          mem_cs     = 1'b1;
          if (mem_ack) begin
            cache_load = 1'b1;
            cache_din  = mem_din;
            cnt_nxt_s  = cnt_r + 3'd1;
            if (last_word_s) begin
              state_nxt_s = FINISH;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        FINISH: begin
          cpu_stall   = 1'b1;
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = 3'd0;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_r, misses_r;
  logic        after_fill_r;

  // statistics; the completing hit right after a refill belongs to an already-counted miss
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_r       <= 32'd0;
      misses_r     <= 32'd0;
      after_fill_r <= 1'b0;
    end else begin
      after_fill_r <= (state_r == FINISH);
      if (state_r == IDLE && req_s && cache_hit && !after_fill_r) begin
        hits_r <= hits_r + 32'd1;
      end else begin
        hits_r <= hits_r;
      end
      if (state_r == IDLE && req_s && !cache_hit) begin
        misses_r <= misses_r + 32'd1;
      end else begin
        misses_r <= misses_r;
      end
    end
  end

  assign hit_count  = rst ? 32'd0 : hits_r;
  assign miss_count = rst ? 32'd0 : misses_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
